// File: rtl/bus1_pkg.sv
// Shared widths, FSM state encoding and command layout for the bus1 master sequencer.
package bus1_pkg;

  localparam int SEL_W  = 3;
  localparam int DATA_W = 32;
  localparam int CMD_W  = SEL_W + DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HOLD,
    ST_WAIT_ACK,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/bus1_cmd_fifo.sv
// Command FIFO with a registered read port; rd_data holds the last popped entry until the next pop.
module bus1_cmd_fifo import bus1_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  // The extra pointer bit distinguishes a full FIFO from an empty one.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/bus1_master_seq.sv
// Write-then-readback sequencer for the 8-register bus host, with ack timeout and a one-entry response slot.
// Define BUS1_MASTER_CHECK_EN to compare the readback against the written data (rsp_mismatch).
module bus1_master_seq import bus1_pkg::*; #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [SEL_W-1:0]  rsp_sel,
  output logic              rsp_timeout,
  output logic              rsp_mismatch,
  output logic              busy,
  output logic              master_req,
  output logic [DATA_W-1:0] master_data,
  output logic [SEL_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] slave_data,
  input  logic              bus_ack
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              master_req_q, master_req_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [SEL_W-1:0]  rsp_sel_q, rsp_sel_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              fifo_pop, fifo_full, fifo_empty;
  cmd_t              fifo_head;

  // The FIFO's registered read port doubles as the latched bus payload.
  bus1_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({cmd_sel, cmd_data}),
    .pop       (fifo_pop),
    .rd_data   (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign cmd_ready   = !fifo_full;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;
  assign master_req  = master_req_q;
  assign master_data = fifo_head.data;
  assign reg_sel     = fifo_head.sel;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_sel     = rsp_sel_q;
  assign rsp_timeout = rsp_timeout_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    master_req_d  = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_sel_d     = rsp_sel_q;
    rsp_timeout_d = rsp_timeout_q;
    fifo_pop      = 1'b0;
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !rsp_valid_q) begin
          fifo_pop     = 1'b1;
          master_req_d = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An ack landing on the final counted cycle still wins over the timeout.
        if (bus_ack) begin
          rsp_data_d    = slave_data;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_sel_d   = fifo_head.sel;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      master_req_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_sel_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      master_req_q  <= master_req_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_sel_q     <= rsp_sel_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

`ifdef BUS1_MASTER_CHECK_EN
  logic rsp_mismatch_q, rsp_mismatch_d;

  // Evaluated in RESP so the flag becomes visible together with rsp_valid.
  always_comb begin
    rsp_mismatch_d = rsp_mismatch_q;
    if (state_q == ST_RESP) begin
      rsp_mismatch_d = !rsp_timeout_q && (rsp_data_q != fifo_head.data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_mismatch_q <= 1'b0;
    end else begin
      rsp_mismatch_q <= rsp_mismatch_d;
    end
  end

  assign rsp_mismatch = rsp_mismatch_q;
`else
  assign rsp_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_bus1_master_seq.sv
// Bench for bus1_master_seq: directed scenarios plus random batches against a transaction-level model.
module tb_bus1_master_seq;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
`ifdef BUS1_MASTER_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  sel;
    logic [31:0] data;
    logic        timeout;
    logic        mismatch;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_sel = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_sel;
  logic        rsp_timeout;
  logic        rsp_mismatch;
  logic        busy;
  logic        master_req;
  logic [31:0] master_data;
  logic [2:0]  reg_sel;
  logic [31:0] slave_data = '0;
  logic        bus_ack = 1'b0;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          req_count = 0;
  int          host_delay = 0;
  logic [31:0] host_mask = '0;
  int          chk_idx = 0;
  rsp_t        got_q[$];
  rsp_t        exp_q[$];

  always #5 clk = ~clk;

  bus1_master_seq #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_sel      (cmd_sel),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_sel      (rsp_sel),
    .rsp_timeout  (rsp_timeout),
    .rsp_mismatch (rsp_mismatch),
    .busy         (busy),
    .master_req   (master_req),
    .master_data  (master_data),
    .reg_sel      (reg_sel),
    .slave_data   (slave_data),
    .bus_ack      (bus_ack)
  );

  // Host: samples the payload during the request, then acks host_delay cycles into WAIT_ACK.
  always begin : host_model
    logic [31:0] cap;
    @(negedge clk);
    if (rst_n === 1'b1 && master_req === 1'b1) begin
      cap = master_data;
      @(posedge clk);
      @(posedge clk);
      repeat (host_delay) @(posedge clk);
      #1;
      bus_ack    = 1'b1;
      slave_data = cap ^ host_mask;
      @(posedge clk);
      #1;
      bus_ack = 1'b0;
    end
  end

  always @(negedge clk) begin : monitor
    rsp_t r;
    if (rst_n === 1'b1 && master_req === 1'b1) req_count++;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      r.sel      = rsp_sel;
      r.data     = rsp_data;
      r.timeout  = rsp_timeout;
      r.mismatch = rsp_mismatch;
      got_q.push_back(r);
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rsp_t model_rsp(input logic [2:0] sel, input logic [31:0] data,
                                     input int delay, input logic [31:0] mask);
    rsp_t r;
    r.sel = sel;
    if (delay < TIMEOUT) begin
      r.data     = data ^ mask;
      r.timeout  = 1'b0;
      r.mismatch = CHECK_EN && (mask != 32'd0);
    end else begin
      r.data     = 32'd0;
      r.timeout  = 1'b1;
      r.mismatch = 1'b0;
    end
    return r;
  endfunction

  // Edges from the command handshake edge (counted as 1) to rsp_valid.
  function automatic int model_latency(input int delay);
    return 6 + ((delay < TIMEOUT) ? delay : TIMEOUT - 1);
  endfunction

  function automatic rsp_t current_rsp();
    rsp_t r;
    r.sel      = rsp_sel;
    r.data     = rsp_data;
    r.timeout  = rsp_timeout;
    r.mismatch = rsp_mismatch;
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_rsp(input string tag, input rsp_t obs, input rsp_t expv);
    check_output({tag, "_sel"}, 64'(obs.sel), 64'(expv.sel));
    check_output({tag, "_data"}, 64'(obs.data), 64'(expv.data));
    check_output({tag, "_timeout"}, 64'(obs.timeout), 64'(expv.timeout));
    check_output({tag, "_mismatch"}, 64'(obs.mismatch), 64'(expv.mismatch));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] sel, input logic [31:0] data,
                                input bit track, input bit rand_ready);
    bit accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1;
    cmd_sel   = sel;
    cmd_data  = data;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      accepted = (cmd_ready === 1'b1);
      tick();
    end
    cmd_valid = 1'b0;
    check_output("cmd_accepted", 64'(accepted), 64'd1);
    if (track) exp_q.push_back(model_rsp(sel, data, host_delay, host_mask));
  endtask

  task automatic wait_rsp(output int edges);
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
  endtask

  task automatic drain(input string tag);
    rsp_ready = 1'b1;
    for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) tick();
    rsp_ready = 1'b0;
    check_output({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (chk_idx < exp_q.size() && chk_idx < got_q.size()) begin
      check_rsp(tag, got_q[chk_idx], exp_q[chk_idx]);
      chk_idx++;
    end
  endtask

  initial begin : stimulus
    int edges;
    int r0;

    repeat (3) @(posedge clk);
    #1;
    check_output("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("reset_master_req", 64'(master_req), 64'd0);
    check_output("reset_master_data", 64'(master_data), 64'd0);
    check_output("reset_reg_sel", 64'(reg_sel), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_rsp("reset_rsp", current_rsp(), '0);
    rst_n = 1'b1;
    tick();

    // Nominal single transaction; response left pending to exercise backpressure next.
    host_delay = 0;
    host_mask  = '0;
    r0 = req_count;
    apply_stimulus(3'd3, 32'hDEADBEEF, 1'b1, 1'b0);
    wait_rsp(edges);
    check_output("nominal_latency", 64'(edges + 1), 64'(model_latency(0)));
    check_output("nominal_req_cycles", 64'(req_count - r0), 64'd1);
    check_rsp("nominal", current_rsp(), exp_q[exp_q.size() - 1]);
    check_output("held_master_data", 64'(master_data), 64'hDEADBEEF);
    check_output("held_reg_sel", 64'(reg_sel), 64'd3);

    r0 = req_count;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(3'(i + 1), $urandom, 1'b1, 1'b0);
    end
    check_output("full_cmd_ready", 64'(cmd_ready), 64'd0);
    check_output("full_busy", 64'(busy), 64'd1);
    repeat (3) tick();
    check_output("backpressure_no_issue", 64'(req_count - r0), 64'd0);
    rsp_ready = 1'b1;
    apply_stimulus(3'd7, $urandom, 1'b1, 1'b0);
    drain("backpressure");
    repeat (3) tick();
    check_output("backpressure_issued", 64'(req_count - r0), 64'd5);
    check_output("backpressure_idle_busy", 64'(busy), 64'd0);

    for (int b = 0; b < 3; b++) begin
      host_delay = int'($urandom_range(0, 3));
      host_mask  = (b == 2) ? ($urandom | 32'd1) : 32'd0;
      for (int n = 0; n < 8; n++) begin
        repeat ($urandom_range(0, 2)) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick();
        end
        apply_stimulus(3'($urandom), $urandom, 1'b1, 1'b1);
      end
      drain("random");
    end
    host_mask = '0;

    // Host acks two cycles after the timeout response is already up.
    host_delay = TIMEOUT + 2;
    apply_stimulus(3'd5, 32'h12345678, 1'b1, 1'b0);
    wait_rsp(edges);
    check_output("timeout_latency", 64'(edges + 1), 64'(model_latency(TIMEOUT + 2)));
    check_rsp("timeout", current_rsp(), exp_q[exp_q.size() - 1]);
    repeat (4) tick();
    check_output("late_ack_rsp_data", 64'(rsp_data), 64'd0);
    check_output("late_ack_rsp_timeout", 64'(rsp_timeout), 64'd1);
    check_output("late_ack_rsp_valid", 64'(rsp_valid), 64'd1);
    check_output("late_ack_busy", 64'(busy), 64'd0);
    drain("timeout");

    host_delay = TIMEOUT - 1;
    apply_stimulus(3'd6, 32'hA5A55A5A, 1'b1, 1'b0);
    wait_rsp(edges);
    check_output("ack_at_limit_latency", 64'(edges + 1), 64'(model_latency(TIMEOUT - 1)));
    check_rsp("ack_at_limit", current_rsp(), exp_q[exp_q.size() - 1]);
    drain("ack_at_limit");

    host_delay = 0;
    host_mask  = 32'h00000001;
    apply_stimulus(3'd2, 32'hDEADBEEF, 1'b1, 1'b0);
    wait_rsp(edges);
    check_output("corrupt_latency", 64'(edges + 1), 64'(model_latency(0)));
    check_rsp("corrupt", current_rsp(), exp_q[exp_q.size() - 1]);
    drain("corrupt");
    host_mask = '0;

    // Two commands in flight, then reset while the first sits in HOLD.
    apply_stimulus(3'd4, 32'hCAFEF00D, 1'b0, 1'b0);
    apply_stimulus(3'd1, 32'h0BADF00D, 1'b0, 1'b0);
    tick();
    check_output("hold_busy", 64'(busy), 64'd1);
    check_output("hold_master_data", 64'(master_data), 64'hCAFEF00D);
    rst_n = 1'b0;
    #1;
    check_output("async_rst_master_req", 64'(master_req), 64'd0);
    check_output("async_rst_master_data", 64'(master_data), 64'd0);
    check_output("async_rst_reg_sel", 64'(reg_sel), 64'd0);
    check_output("async_rst_busy", 64'(busy), 64'd0);
    check_output("async_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check_output("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    apply_stimulus(3'd0, 32'h00000001, 1'b1, 1'b0);
    wait_rsp(edges);
    check_output("post_reset_latency", 64'(edges + 1), 64'(model_latency(0)));
    check_rsp("post_reset", current_rsp(), exp_q[exp_q.size() - 1]);
    drain("post_reset");
    repeat (10) tick();
    check_output("flushed_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("flushed_busy", 64'(busy), 64'd0);
    check_output("flushed_rsp_count", 64'(got_q.size()), 64'(exp_q.size()));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
